// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with an AXI-Stream fed TX FIFO and run-time parity/stop/baud settings.
// Frame settings are captured when a word is popped, so config changes only affect later frames.
`timescale 1ns/1ps
module uart_tx_fifo_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_RATE   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int PRESCALE_W = 19
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [PRESCALE_W-1:0]         cfg_prescale,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [PRESCALE_W-1:0] DEF_PRESCALE = PRESCALE_W'(CLK_RATE / BAUD_RATE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d;
  logic                  tready_q;

  logic [2:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_second_q, stop_second_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;

  logic                  push, pop, fifo_empty, bit_done;
  logic [PRESCALE_W-1:0] eff_presc;
  logic [DATA_WIDTH-1:0] head;

  assign s_axis_tready = tready_q;
  assign txd           = txd_q;
  assign busy          = busy_q;
  assign fifo_level    = level_q;
  assign head          = mem_q[rd_ptr_q];

  always_comb begin
    eff_presc     = (cfg_prescale == '0) ? DEF_PRESCALE : cfg_prescale;
    fifo_empty    = (level_q == '0);
    bit_done      = (cnt_q == '0);
    push          = s_axis_tvalid && tready_q;
    pop           = 1'b0;
    state_d       = state_q;
    cnt_d         = bit_done ? cnt_q : cnt_q - PRESCALE_W'(1);
    presc_d       = presc_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    par_en_d      = par_en_q;
    par_bit_d     = par_bit_q;
    stop2_d       = stop2_q;
    stop_second_d = stop_second_q;
    txd_d         = txd_q;
    busy_d        = busy_q;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          cnt_d   = presc_q - PRESCALE_W'(1);
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d = presc_q - PRESCALE_W'(1);
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              txd_d   = par_bit_q;
            end else begin
              state_d       = S_STOP;
              txd_d         = 1'b1;
              stop_second_d = 1'b0;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d       = S_STOP;
          cnt_d         = presc_q - PRESCALE_W'(1);
          txd_d         = 1'b1;
          stop_second_d = 1'b0;
        end
      end
      S_STOP: begin
        // Second stop bit reuses the bit counter so it never needs 2P-1 headroom.
        if (bit_done) begin
          if (stop2_q && !stop_second_q) begin
            stop_second_d = 1'b1;
            cnt_d         = presc_q - PRESCALE_W'(1);
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (pop) begin
      state_d   = S_START;
      txd_d     = 1'b0;
      busy_d    = 1'b1;
      presc_d   = eff_presc;
      cnt_d     = eff_presc - PRESCALE_W'(1);
      shift_d   = head;
      par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_bit_d = (^head) ^ (cfg_parity == 2'b10);
      stop2_d   = cfg_stop2;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      tready_q      <= 1'b0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      presc_q       <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
      txd_q         <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q       <= level_d;
      tready_q      <= (level_d != LW'(FIFO_DEPTH));
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      presc_q       <= presc_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      par_en_q      <= par_en_d;
      par_bit_q     <= par_bit_d;
      stop2_q       <= stop2_d;
      stop_second_q <= stop_second_d;
      txd_q         <= txd_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Self-checking bench for uart_tx_fifo_cfg: directed vector table, corner sequences and
// random frames checked against a bit-level frame model driven by observed pushes.
`timescale 1ns/1ps
module tb_uart_tx_fifo_cfg;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 19;
  localparam int DEF_P = 868;
  localparam int LIM   = 40000;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [PW-1:0] cfg_prescale;
  logic [1:0]    cfg_parity;
  logic          cfg_stop2;
  logic          txd;
  logic          busy;
  logic [2:0]    fifo_level;

  uart_tx_fifo_cfg #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .cfg_prescale(cfg_prescale), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .txd(txd), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Expected line level for bit slot k of a frame: start, LSB-first data, optional parity, stops.
  function automatic logic exp_txd(input logic [DW-1:0] w, input int par_mode, input int k);
    logic [DW-1:0] ww;
    ww = w;
    if (k == 0) return 1'b0;
    if (k <= DW) return ww[k-1];
    if (k == DW + 1 && (par_mode == 1 || par_mode == 2))
      return (($countones(ww) % 2) == 1) ^ (par_mode == 2);
    return 1'b1;
  endfunction

  // Monitor / reference model state (written only by the monitor process)
  logic [DW-1:0] exp_q[$];
  int frame_err [64];
  int frame_word[64];
  int frames_done = 0;
  int idle_err = 0;
  int inv_err = 0;
  int full_seen = 0;
  logic rst_prev = 1'b0;
  bit in_frame = 0;
  logic [DW-1:0] f_word;
  int f_p, f_par, f_len, f_off, f_err;
  int cap_p = 4, cap_par = 0;
  logic cap_st2 = 1'b0;

  always begin
    @(negedge clk);
    if (rst !== 1'b1) begin
      in_frame = 0;
      exp_q.delete();
    end else begin
      if (rst_prev === 1'b1 && s_axis_tready !== (fifo_level != 3'(DEPTH))) inv_err++;
      if (fifo_level == 3'(DEPTH) && s_axis_tready === 1'b0) full_seen++;
      if (!in_frame && txd === 1'b0) begin
        if (exp_q.size() == 0) idle_err++;
        else begin
          f_word   = exp_q.pop_front();
          f_p      = cap_p;
          f_par    = cap_par;
          f_len    = f_p * (1 + DW + ((f_par == 1 || f_par == 2) ? 1 : 0) + (cap_st2 ? 2 : 1));
          f_off    = 0;
          f_err    = 0;
          in_frame = 1;
        end
      end else if (!in_frame && (busy !== 1'b0 || txd !== 1'b1)) begin
        idle_err++;
      end
      if (in_frame) begin
        if (txd !== exp_txd(f_word, f_par, f_off / f_p) || busy !== 1'b1) f_err++;
        f_off++;
        if (f_off == f_len) begin
          in_frame = 0;
          if (frames_done < 64) begin
            frame_err[frames_done]  = f_err;
            frame_word[frames_done] = int'(f_word);
          end
          frames_done++;
        end
      end
    end
    rst_prev = rst;
    // Just before the next edge: settings seen by a pop at that edge, and any handshake.
    #4;
    cap_p   = (cfg_prescale == '0) ? DEF_P : int'(cfg_prescale);
    cap_par = int'(cfg_parity);
    cap_st2 = cfg_stop2;
    if (rst === 1'b1 && s_axis_tvalid === 1'b1 && s_axis_tready === 1'b1) exp_q.push_back(s_axis_tdata);
  end

  int next_frame = 0;
  int exp_frames = 0;

  task automatic drain_frames();
    while (next_frame < frames_done && next_frame < 64) begin
      check($sformatf("frame%0d_word%02h_bit_errors", next_frame, frame_word[next_frame]),
            frame_err[next_frame], 0);
      next_frame++;
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && n < LIM) begin @(posedge clk); #1; n++; end
    if (n >= LIM) check("push_tready_timeout", 1, 0);
    @(posedge clk); #1;
    exp_frames++;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || fifo_level != 0) && n < LIM) begin @(posedge clk); #1; n++; end
    check({name, "_reaches_idle"}, (n < LIM) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Counts busy-high cycles of one busy interval; optionally probes txd and changes prescale.
  task automatic measure(input int chg_at, input int chg_p, input int probe_at,
                         output int len, output logic probe);
    int n = 0;
    len   = 0;
    probe = 1'bx;
    @(negedge clk);
    while (busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    while (busy === 1'b1 && len < LIM) begin
      if (len == probe_at) probe = txd;
      if (len == chg_at) cfg_prescale = PW'(chg_p);
      len++;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            presc;
    logic [1:0]    par;
    logic          st2;
    int            len;
    int            par_bit;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   len;
    logic probe;
    int   fr0;
    int   busy_cnt;

    vecs[0] = '{8'h55, 4, 2'b00, 1'b0, 40, -1};
    vecs[1] = '{8'h07, 4, 2'b01, 1'b0, 44, 1};
    vecs[2] = '{8'h07, 4, 2'b10, 1'b0, 44, 0};
    vecs[3] = '{8'hC3, 1, 2'b01, 1'b1, 12, 0};
    vecs[4] = '{8'hA3, 3, 2'b11, 1'b1, 33, -1};

    rst = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    cfg_prescale = PW'(4); cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", txd, 1);
    check("reset_busy", busy, 0);
    check("reset_level", fifo_level, 0);
    check("reset_tready", s_axis_tready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("tready_after_release", s_axis_tready, 1);

    foreach (vecs[i]) begin
      cfg_prescale = PW'(vecs[i].presc);
      cfg_parity   = vecs[i].par;
      cfg_stop2    = vecs[i].st2;
      push(vecs[i].data);
      s_axis_tvalid = 1'b0;
      measure(-1, 0, (1 + DW) * vecs[i].presc + vecs[i].presc / 2, len, probe);
      check($sformatf("vec%0d_busy_len", i), len, vecs[i].len);
      if (vecs[i].par_bit >= 0) check($sformatf("vec%0d_parity_bit", i), probe, vecs[i].par_bit);
      wait_idle($sformatf("vec%0d", i));
      drain_frames();
    end

    // Back-to-back frames with two stop bits: busy stays high across both.
    cfg_prescale = PW'(3); cfg_parity = 2'b01; cfg_stop2 = 1'b1;
    push(8'hA3);
    push(8'h3C);
    s_axis_tvalid = 1'b0;
    measure(-1, 0, 36, len, probe);
    check("b2b_busy_len", len, 72);
    check("b2b_second_start", probe, 0);
    wait_idle("b2b");
    drain_frames();

    // FIFO fill with tvalid held high.
    cfg_prescale = PW'(16); cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    fr0 = frames_done;
    begin
      int fs0 = full_seen;
      for (int i = 0; i < 6; i++) push(8'(8'h10 + 8'(i * 17)));
      s_axis_tvalid = 1'b0;
      check("fifo_full_tready_low", (full_seen > fs0) ? 1 : 0, 1);
    end
    wait_idle("fifo6");
    check("fifo6_frame_count", frames_done - fr0, 6);
    drain_frames();

    // Prescale change mid-frame only affects the following frame.
    cfg_prescale = PW'(4);
    push(8'h5A);
    push(8'hC3);
    s_axis_tvalid = 1'b0;
    measure(10, 8, 40, len, probe);
    check("midcfg_busy_len", len, 120);
    check("midcfg_second_start", probe, 0);
    wait_idle("midcfg");
    drain_frames();

    // Prescale 0 selects the default bit period.
    cfg_prescale = '0;
    push(8'h01);
    s_axis_tvalid = 1'b0;
    measure(-1, 0, DEF_P - 1, len, probe);
    check("defp_busy_len", len, 10 * DEF_P);
    check("defp_start_last_cycle", probe, 0);
    wait_idle("defp");
    drain_frames();

    // Random configurations and bursts.
    for (int r = 0; r < 8; r++) begin
      int nw;
      cfg_prescale = PW'($urandom_range(6, 1));
      cfg_parity   = 2'($urandom_range(3, 0));
      cfg_stop2    = 1'($urandom_range(1, 0));
      nw = $urandom_range(3, 1);
      for (int k = 0; k < nw; k++) push(8'($urandom));
      s_axis_tvalid = 1'b0;
      wait_idle($sformatf("rand%0d", r));
      drain_frames();
    end

    // Reset in the middle of DATA with three words queued.
    cfg_prescale = PW'(16); cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    for (int k = 0; k < 4; k++) push(8'(8'hE0 + 8'(k)));
    s_axis_tvalid = 1'b0;
    repeat (16 * 3) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    check("pre_reset_level", fifo_level, 3);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midreset_txd", txd, 1);
    check("midreset_busy", busy, 0);
    check("midreset_level", fifo_level, 0);
    check("midreset_tready", s_axis_tready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_tready_back", s_axis_tready, 1);
    fr0 = frames_done;
    busy_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || txd !== 1'b1) busy_cnt++;
    end
    check("post_reset_no_activity", busy_cnt, 0);
    check("post_reset_no_frames", frames_done - fr0, 0);
    exp_frames -= 4;

    drain_frames();
    check("total_frames", frames_done, exp_frames);
    check("idle_line_errors", idle_err, 0);
    check("tready_vs_level_errors", inv_err, 0);
    check("model_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
Next-generation UART transmitter for the FPGA debug/console path. It accepts words on an AXI-Stream slave into an internal FIFO and serialises them LSB-first on txd. Data width, FIFO depth and clock/baud defaults are set by parameters. Parity mode, stop-bit count and bit period are run-time configurable. The block sits between the core's MMIO/console logic and the board TX pin.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 16, TX FIFO entries; power of two, minimum 2.
CLK_RATE, 100000000, board clock in Hz.
BAUD_RATE, 115200, default baud; DEF_PRESCALE = CLK_RATE/BAUD_RATE.
PRESCALE_W, 19, width of the bit-period counter and of cfg_prescale.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-low.
s_axis_tdata  in  DATA_WIDTH  word to transmit.
s_axis_tvalid  in  1  word valid.
s_axis_tready  out  1  FIFO can accept; equals !full.
cfg_prescale  in  PRESCALE_W  clocks per bit; 0 selects DEF_PRESCALE.
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none (reserved).
cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits.
txd  out  1  serial output, idle high.
busy  out  1  frame in progress.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is synchronous: on any clk edge with rst==0, the block does the following.
  - Outputs: txd=1, busy=0, s_axis_tready=0, fifo_level=0.
  - FIFO pointers are cleared and its contents flushed.
  - FSM goes to IDLE; a frame in flight is abandoned, and txd is 1 after that edge.
- s_axis_tready is registered: 1 from the first edge after reset release while the FIFO is not full.
- FIFO write: s_axis_tvalid && s_axis_tready at an edge.
- FIFO read: the FSM pops in IDLE when the FIFO is non-empty.
- A simultaneous push and pop leaves fifo_level unchanged; a push when full is impossible because tready=0.
- fifo_level updates on the same edge as the push/pop.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty. On that edge the block pops the head, sets txd=0 and busy=1, and latches the effective prescale P, parity mode and stop count.
  - Config changes mid-frame do not affect the current frame.
  - START lasts P cycles, then goes to DATA.
  - DATA sends bit 0 first; each bit lasts P cycles. After DATA_WIDTH bits it goes to PARITY if parity is enabled, otherwise to STOP.
  - PARITY lasts P cycles. Even mode sends the XOR of the data bits; odd mode sends its inverse.
  - STOP holds txd=1 for P cycles (one stop bit) or 2P cycles (two stop bits). Then go to IDLE with busy=0, or directly to START if the FIFO is non-empty, giving back-to-back frames with no idle gap.
- Bit-period counter: loaded with P-1 at each bit boundary and counts down to 0; P=1 is legal.
- Latency: a word accepted at edge N into an empty FIFO with an idle FSM is popped at edge N+1, so txd falls after edge N+1.
- Frame length = P*(1+DATA_WIDTH+par+stops) cycles, where par is 0/1 and stops is 1/2.
- busy is 1 from the start-bit edge through the last stop-bit cycle. busy does not reflect FIFO contents; idle status is busy==0 && fifo_level==0.
- txd is driven straight from a register (glitch-free).

Test Plan:
- DATA_WIDTH=8, cfg_prescale=4, no parity, 1 stop, send 0x55 -> txd low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. Frame is 40 cycles; busy=1 for exactly 40 cycles.
- Even parity, prescale=4, send 0x07 -> parity bit 1. Odd parity, send 0x07 -> parity bit 0. Both frames are 44 cycles.
- cfg_stop2=1, prescale=3, push 0xA3 then 0x3C back-to-back -> each frame is 36 cycles. The second start bit falls immediately after 6 stop cycles, and busy never drops between frames.
- FIFO_DEPTH=4, prescale=16, push 6 words with tvalid held high -> tready drops once fifo_level reaches 4 (one word already popped). All 6 bytes appear on txd in order; none are lost or duplicated.
- Assert rst low for 1 cycle in the middle of DATA with 3 words queued -> after that edge txd=1, busy=0, fifo_level=0 and tready=0. tready returns to 1 one cycle after release, and no further frames are sent.
- cfg_prescale=0 -> bit period equals DEF_PRESCALE (868 at defaults). Changing cfg_prescale from 4 to 8 mid-frame -> current frame keeps 4-cycle bits; the next frame uses 8.
